// File: rtl/cfg_chain_pkg.sv
// -----------------------------------------------------------------------------
// cfg_chain_pkg
// Shared definitions for the configuration shift chain:
//   - cfg_state_e : chain controller state encoding (IDLE, SHIFT, COMMIT, DONE)
//   - chain_len   : number of stored configuration bits per block
//   - count_width : width of the bit counter for a given chain length
// No ports (package).
// -----------------------------------------------------------------------------
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } cfg_state_e;

    // Stored bits per block: every group carries its LUT bits then its mode bits.
    function automatic int chain_len(input int num_groups, input int x_bits, input int q_bits);
        return num_groups * (x_bits + q_bits);
    endfunction

    // Two spare codes above the chain length leave room for an optional
    // trailing parity bit without the counter ever wrapping.
    function automatic int count_width(input int len);
        return $clog2(len + 2);
    endfunction

endpackage

// File: rtl/cfg_bit_counter.sv
// -----------------------------------------------------------------------------
// cfg_bit_counter
// Counts configuration bits accepted by the chain controller.
// Ports:
//   clk_i    : clock, rising edge
//   reset_ni : synchronous active-low reset (count -> 0)
//   clr_i    : synchronous clear, has priority over en_i
//   en_i     : increment by one
//   tc_o     : high while the count equals TERM-1, i.e. the next accepted
//              bit is the last one of the block
// -----------------------------------------------------------------------------
module cfg_bit_counter #(
    parameter int TERM = 26,
    parameter int W    = 5
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] TC_VAL = W'(TERM - 1);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-count selection: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/cfg_shift_chain.sv
// -----------------------------------------------------------------------------
// cfg_shift_chain
// Serially loads NUM_GROUPS configuration words (X_BITS LUT bits + Q_BITS mode
// bits each) into a shadow register, commits them atomically to the active
// outputs, then forwards the program token and the rest of the bitstream to
// the next block in the daisy chain.
//
// Optional feature (macro CFG_PARITY_CHK_EN): one extra even-parity bit
// follows the configuration bits; a failing check blocks the commit and
// raises cfg_err while the token/bypass still proceed.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous active-low reset
//   prgm_b_in     : global program strobe, active-low
//   cb_prgm_b_in  : program token from upstream, active-high
//   bit_in_CB     : serial configuration bit
//   cb_prgm_b_out : token to downstream (registered)
//   bit_out_CB    : serial bypass to downstream (registered)
//   cfg_x         : committed LUT bits
//   cfg_q         : committed mode bits
//   cfg_done      : configuration committed
//   cfg_err       : parity failure (0 when parity checking is not built)
// -----------------------------------------------------------------------------
module cfg_shift_chain
    import cfg_chain_pkg::*;
#(
    parameter int NUM_GROUPS = 2,
    parameter int X_BITS     = 9,
    parameter int Q_BITS     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prgm_b_in,
    input  logic                         cb_prgm_b_in,
    input  logic                         bit_in_CB,
    output logic                         cb_prgm_b_out,
    output logic                         bit_out_CB,
    output logic [NUM_GROUPS*X_BITS-1:0] cfg_x,
    output logic [NUM_GROUPS*Q_BITS-1:0] cfg_q,
    output logic                         cfg_done,
    output logic                         cfg_err
);

    localparam int CHAIN_LEN = chain_len(NUM_GROUPS, X_BITS, Q_BITS);
    localparam int GRP_LEN   = X_BITS + Q_BITS;
    localparam int CNT_W     = count_width(CHAIN_LEN);
`ifdef CFG_PARITY_CHK_EN
    localparam int NUM_BITS  = CHAIN_LEN + 1;
`else
    localparam int NUM_BITS  = CHAIN_LEN;
`endif

    cfg_state_e                   state_q, state_d;
    logic [CHAIN_LEN-1:0]         shadow_q, shadow_d;
    logic [NUM_GROUPS*X_BITS-1:0] x_q, x_d;
    logic [NUM_GROUPS*Q_BITS-1:0] mode_q, mode_d;
    logic                         done_q, done_d;
    logic                         token_q, token_d;
    logic                         bout_q, bout_d;
`ifdef CFG_PARITY_CHK_EN
    logic                         par_q, par_d;
    logic                         err_q, err_d;
`endif

    logic                         en_s;
    logic                         tc_s;
    logic                         store_s;
    logic                         cnt_clr_s;
    logic                         cnt_en_s;
    logic [CHAIN_LEN-1:0]         shift_s;
    logic [NUM_GROUPS*X_BITS-1:0] x_map_s;
    logic [NUM_GROUPS*Q_BITS-1:0] mode_map_s;

    assign en_s    = ~prgm_b_in & cb_prgm_b_in;
    assign shift_s = {shadow_q[CHAIN_LEN-2:0], bit_in_CB};

`ifdef CFG_PARITY_CHK_EN
    // The trailing parity bit is consumed but never enters the shadow.
    assign store_s = ~tc_s;
`else
    assign store_s = 1'b1;
`endif

    // Shadow-to-output bit mapping: per group, LUT bits sit below mode bits.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_map
        for (genvar i = 0; i < X_BITS; i++) begin : g_x
            assign x_map_s[g*X_BITS+i] = shadow_q[g*GRP_LEN+i];
        end
        for (genvar i = 0; i < Q_BITS; i++) begin : g_q
            assign mode_map_s[g*Q_BITS+i] = shadow_q[g*GRP_LEN+X_BITS+i];
        end
    end

    cfg_bit_counter #(
        .TERM (NUM_BITS),
        .W    (CNT_W)
    ) u_cnt (
        .clk_i    (clk),
        .reset_ni (reset),
        .clr_i    (cnt_clr_s),
        .en_i     (cnt_en_s),
        .tc_o     (tc_s)
    );

    // Next-state and next-output logic of the chain controller.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        x_d       = x_q;
        mode_d    = mode_q;
        done_d    = done_q;
        token_d   = 1'b0;
        bout_d    = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
`ifdef CFG_PARITY_CHK_EN
        par_d     = par_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_s) begin
                    shadow_d = shift_s;
                    cnt_en_s = 1'b1;
                    done_d   = 1'b0;
`ifdef CFG_PARITY_CHK_EN
                    par_d    = bit_in_CB;
                    err_d    = 1'b0;
`endif
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (en_s) begin
                    cnt_en_s = 1'b1;
                    if (store_s) begin
                        shadow_d = shift_s;
                    end else begin
                        shadow_d = shadow_q;
                    end
`ifdef CFG_PARITY_CHK_EN
                    par_d    = par_q ^ bit_in_CB;
`endif
                    if (tc_s) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    // Abort: partial load is discarded, active outputs untouched.
                    cnt_clr_s = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                cnt_clr_s = 1'b1;
                token_d   = 1'b1;
                bout_d    = bit_in_CB;
                state_d   = ST_DONE;
`ifdef CFG_PARITY_CHK_EN
                if (par_q) begin
                    err_d  = 1'b1;
                    done_d = 1'b0;
                end else begin
                    x_d    = x_map_s;
                    mode_d = mode_map_s;
                    err_d  = 1'b0;
                    done_d = 1'b1;
                end
`else
                x_d       = x_map_s;
                mode_d    = mode_map_s;
                done_d    = 1'b1;
`endif
            end
            ST_DONE: begin
                if (prgm_b_in || !cb_prgm_b_in) begin
                    state_d = ST_IDLE;
                end else begin
                    token_d = 1'b1;
                    bout_d  = bit_in_CB;
                    state_d = ST_DONE;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs, synchronous reset first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            x_q      <= '0;
            mode_q   <= '0;
            done_q   <= 1'b0;
            token_q  <= 1'b0;
            bout_q   <= 1'b0;
`ifdef CFG_PARITY_CHK_EN
            par_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            token_q  <= token_d;
            bout_q   <= bout_d;
`ifdef CFG_PARITY_CHK_EN
            par_q    <= par_d;
            err_q    <= err_d;
`endif
        end
    end

    assign cb_prgm_b_out = token_q;
    assign bit_out_CB    = bout_q;
    assign cfg_x         = x_q;
    assign cfg_q         = mode_q;
    assign cfg_done      = done_q;
`ifdef CFG_PARITY_CHK_EN
    assign cfg_err       = err_q;
`else
    assign cfg_err       = 1'b0;
`endif

endmodule

// File: doc/cfg_shift_chain.md
# cfg_shift_chain

Parametrised configuration shift chain for the reconfigurable emulator fabric. Serially loads NUM_GROUPS logic-block configuration words (X_BITS LUT bits plus Q_BITS mode bits per group) into a shadow register. It commits them atomically to the active outputs, so configuration never glitches mid-load. It then passes the program token and the remaining bitstream to the next block in the daisy chain. This is the successor of the fixed two-group chain: depth is generic, commit is double-buffered, and the block tracks its own bit count, handles abort, and does the hand-off itself.

## Interface
Parameters:
- NUM_GROUPS, 2: number of configurable groups.
- X_BITS, 9: LUT bits per group.
- Q_BITS, 4: mode/select bits per group.
- Derived localparam CHAIN_LEN = NUM_GROUPS*(X_BITS+Q_BITS), 26 at defaults.

Ports:
- clk  in  1: single clock; all state on the rising edge.
- reset  in  1: synchronous, active-low reset.
- prgm_b_in  in  1: global program strobe, active-low.
- cb_prgm_b_in  in  1: program token from the upstream block, active-high.
- bit_in_CB  in  1: serial configuration bit.
- cb_prgm_b_out  out  1: token to the downstream block; registered.
- bit_out_CB  out  1: serial bypass to downstream; registered.
- cfg_x  out  NUM_GROUPS*X_BITS: committed LUT bits.
- cfg_q  out  NUM_GROUPS*Q_BITS: committed mode bits.
- cfg_done  out  1: this block's configuration committed.
- cfg_err  out  1: parity failure (see Configuration).

## Operation
- Enable condition en = (prgm_b_in==0 && cb_prgm_b_in==1).
- The FSM has four states: IDLE, SHIFT, COMMIT, DONE.
- IDLE:
  - If en, shift one bit, set count=1, clear cfg_done and cfg_err, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - While en, shift each cycle with shadow[0]<=bit_in_CB and shadow[i]<=shadow[i-1], and increment count.
  - The edge that shifts bit number CHAIN_LEN goes to COMMIT.
  - If en drops, abort to IDLE. Count is cleared, active outputs are unchanged, and no token is passed.
- COMMIT (1 cycle):
  - Load the active registers from shadow.
  - bit_out_CB<=bit_in_CB.
  - Go to DONE.
- DONE:
  - cb_prgm_b_out=1.
  - bit_out_CB<=bit_in_CB every cycle.
  - When prgm_b_in returns high, go to IDLE. The token drops, and cfg_x, cfg_q and cfg_done are retained.
  - If cb_prgm_b_in drops while prgm_b_in is low, also go to IDLE.
- Bit mapping: shadow index j = g*(X_BITS+Q_BITS)+i.
  - i<X_BITS maps to cfg_x[g*X_BITS+i].
  - Otherwise it maps to cfg_q[g*Q_BITS+i-X_BITS].
  - The first bit shifted lands at shadow[CHAIN_LEN-1], i.e. the MSB of cfg_q of the last group.
- bit_out_CB is 0 outside COMMIT and DONE.
- Count width is $clog2(CHAIN_LEN+2). It never wraps, because the FSM leaves SHIFT at CHAIN_LEN.

## Timing
- Cycle 0 is the first cycle in which en is sampled high. Own bits are sampled in cycles 0..CHAIN_LEN-1.
- COMMIT occurs at cycle CHAIN_LEN.
- cfg_x, cfg_q, cfg_done and cb_prgm_b_out all become valid at cycle CHAIN_LEN+1.
- Bypass latency is 1 cycle. The upstream bit at cycle CHAIN_LEN+k appears on bit_out_CB at cycle CHAIN_LEN+k+1, aligned with downstream cycle 0 at k=0. The source stream must be contiguous.
- Reset (reset==0 at an edge) takes priority over everything, including mid-shift. After reset:
  - state=IDLE, count=0, shadow=0;
  - cfg_x=0, cfg_q=0;
  - cfg_done=0, cfg_err=0;
  - cb_prgm_b_out=0, bit_out_CB=0.

## Configuration
- Macro CFG_PARITY_CHK_EN, defined: CHAIN_LEN+1 bits are shifted. The final bit is even parity over all preceding bits and is not stored in shadow.
  - A running XOR register tracks parity.
  - At COMMIT, if the XOR of all CHAIN_LEN+1 bits is nonzero, the load is skipped, active outputs hold, cfg_err=1 and cfg_done=0.
  - The token and bypass still proceed, so the chain does not stall.
  - All Timing figures shift by +1.
- Macro not defined: no parity bit, and cfg_err is tied to 0.

## Structure
- Package cfg_chain_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT, DONE);
  - a chain_len(NUM_GROUPS, X_BITS, Q_BITS) function;
  - the count-width helper.
- Sub-module cfg_bit_counter: counter with clear and terminal-count output, and an enable input. Instantiated once.

## Test plan
- Hold reset low 3 cycles with en active -> all outputs 0, nothing shifts; release -> state IDLE.
- Defaults; stream bit 0 =1, bits 1..25 =0 -> at cycle 27: cfg_q=8'h80, cfg_x=0, cfg_done=1, cb_prgm_b_out=1.
- Load all-ones, then reprogram and raise prgm_b_in at cycle 10 -> cfg_x and cfg_q stay all-ones, cfg_done=0, token never rises, state IDLE.
- Cascade two instances, 52-bit stream -> downstream sees its cycle 0 at upstream cycle 27; downstream cfg_done rises at upstream cycle 54 with bits 26..51.
- Pull reset low at cycle 5 of shifting -> all outputs and count 0; a fresh 26-bit load afterwards succeeds.
- CFG_PARITY_CHK_EN with a wrong parity bit -> cfg_err=1, cfg_done=0, outputs unchanged, cb_prgm_b_out=1 at cycle 28; with correct parity -> commit and cfg_err=0.
